fsm_stepper: RTL
================

Name: fsm_stepper

Overview:
- Parametrised, multi-channel successor to the single-bit toggle FSM.
- Each channel is an independent modulo-N_STATES Moore state machine. It steps up or down on its `in` input, supports synchronous load, and flags wrap-around.
- With N_STATES=2 and dir=0, a channel behaves exactly like the original toggle machine.
- Sits in control/sequence logic, where it feeds phase selects and round-robin pointers.

Parameters:
- CH, 4, number of independent channels (>=1).
- N_STATES, 2, states per channel (>=2). Values 0..N_STATES-1.
- STW, derived localparam = max(1, $clog2(N_STATES)), per-channel state width.

Ports:
- clk  in  1  clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- en  in  CH  per-channel enable; when 0 the channel holds (load still honoured).
- in  in  CH  per-channel step request.
- dir  in  CH  per-channel direction: 0 = up (+1), 1 = down (-1).
- load  in  CH  per-channel synchronous load strobe.
- load_val  in  CH*STW  load values; channel k uses bits [k*STW +: STW].
- state_out  out  CH*STW  current state of each channel, driven directly from the state register.
- wrap  out  CH  one-cycle pulse, asserted in the cycle state_out shows the wrapped value.
- any_wrap  out  1  OR of wrap.
- err  out  1  sticky out-of-range-load flag.

Behaviour:
- Reset (async, active-high): all states = 0, wrap = 0, any_wrap = 0, err = 0. Reset mid-operation overrides everything immediately, with no wait for a clock edge.
- Per-channel next-state priority, evaluated at each rising clk:
  1. load=1 and load_val < N_STATES: state <= load_val; wrap <= 0. Loading never wraps.
  2. load=1 and load_val >= N_STATES: state unchanged; wrap <= 0; err <= 1.
  3. en=1 and step asserted, dir=0: state <= (state==N_STATES-1) ? 0 : state+1. wrap <= (state==N_STATES-1).
  4. en=1 and step asserted, dir=1: state <= (state==0) ? N_STATES-1 : state-1. wrap <= (state==0).
  5. Otherwise: state holds; wrap <= 0.
- "Step asserted" means in=1 at the clock edge (level-sensitive). With the optional feature compiled in, it means an in rising edge instead (see Optional Feature).
- Latency: one clock from in/load to state_out/wrap. Outputs are registered and have no combinational path from inputs.
- Simultaneous load and step on one channel: load wins.
- Channels are fully independent. Activity on one channel never affects another.
- Arithmetic is at STW width with explicit wrap at N_STATES. This applies even when N_STATES is not a power of two; encoded values >= N_STATES are never reached.
- err is set only by an out-of-range load and is cleared only by areset.
- N_STATES=2, CH=1, en=1, dir=0, no load: state toggles on every clock with in=1, matching the legacy toggle FSM.

Optional Feature:
- Macro: FSM_STEPPER_EDGE_EN.
- Defined: each channel registers `in`, and a step occurs only on a 0->1 transition (in & ~in_q).
  - Holding in high for multiple cycles produces a single step.
  - in_q resets to 0, so in=1 in the first cycle after reset counts as an edge.
  - in_q updates every cycle regardless of en or load.
- Undefined: level-sensitive stepping as described above; no in_q registers exist.

Decomposition:
- Package fsm_stepper_pkg contains:
  - DIR_UP=1'b0 and DIR_DOWN=1'b1 constants.
  - A function computing STW from N_STATES.
- Sub-module fsm_stepper_ch:
  - Contains one channel: state register, wrap register, optional in_q, next-state logic, and a local out-of-range flag.
  - Parameters: N_STATES, STW.
- Top level (fsm_stepper):
  - Generate-loop instantiates CH copies of fsm_stepper_ch.
  - ORs the per-channel wrap and err bits; err is held in a top-level sticky register.

Test Plan:
- Reset: assert areset mid-count with ch0 at state 3 (N_STATES=5) -> state_out, wrap, and err go to 0 asynchronously, before the next edge.
- Up wrap: N_STATES=5, ch0 en=1, dir=0, in=1 for 6 cycles -> state sequence 1,2,3,4,0,1. wrap=1 only in the cycle state reads 0; any_wrap mirrors it.
- Down wrap: ch1 starts at 0, dir=1, one step -> state=4, wrap pulses once. A further step -> 3 with no wrap.
- Load priority: ch2 load=1, load_val=3, in=1, en=1 in the same cycle -> state=3, wrap=0. Then load_val=7 (N_STATES=5) -> state stays 3 and err=1 until areset.
- Independence and enable: ch3 en=0, in=1 for 4 cycles while ch0 steps -> ch3 holds at 0 and ch0 advances by 4.
- Edge mode (FSM_STEPPER_EDGE_EN): hold in=1 for 5 cycles -> exactly one step. Pulse in 1,0,1,0 -> two steps. Without the macro, the same 5-cycle hold gives five steps.

Source files
------------

// File: rtl/fsm_stepper_pkg.sv
// Shared constants and helpers for the multi-channel stepper FSM.
package fsm_stepper_pkg;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Per-channel state width: enough bits for 0..n_states-1, never less than one.
   function automatic int calc_stw(input int n_states);
      int w;
      w = $clog2(n_states);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fsm_stepper_ch.sv
// One stepper channel: a modulo-N_STATES up/down counter with synchronous load,
// a registered wrap pulse and a combinational out-of-range-load indication.
// Build option FSM_STEPPER_EDGE_EN: step on rising edges of step_req instead of its level.
module fsm_stepper_ch
   import fsm_stepper_pkg::*;
#(
   parameter int N_STATES = 2,
   parameter int STW      = 1
) (
   input  logic           clk,
   input  logic           areset,
   input  logic           en,
   input  logic           step_req,
   input  logic           dir,
   input  logic           load,
   input  logic [STW-1:0] load_val,
   output logic [STW-1:0] state,
   output logic           wrap,
   output logic           load_err
);

   // Comparisons are done one bit wider so N_STATES == 2**STW is still representable.
   localparam logic [STW:0]   N_EXT   = (STW+1)'(N_STATES);
   localparam logic [STW-1:0] MAX_VAL = STW'(N_STATES - 1);

   logic [STW-1:0] state_q, state_d;
   logic           wrap_q, wrap_d;
   logic           step;
   logic           load_ok;

`ifdef FSM_STEPPER_EDGE_EN
   logic in_q, in_d;

   // The previous step_req sample is tracked every cycle, independent of en and load.
   always_comb begin
      in_d = step_req;
   end

   // Holds last cycle's step_req so a held request produces only one step.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in_d;
      end
   end

   assign step = step_req & ~in_q;
`else
   assign step = step_req;
`endif

   assign load_ok  = ({1'b0, load_val} < N_EXT);
   assign load_err = load & ~load_ok;

   // Next state: load beats stepping; an out-of-range load leaves the state alone.
   always_comb begin
      state_d = state_q;
      wrap_d  = 1'b0;
      if (load) begin
         if (load_ok) begin
            state_d = load_val;
         end
      end else if (en && step) begin
         if (dir == DIR_UP) begin
            if (state_q == MAX_VAL) begin
               state_d = '0;
               wrap_d  = 1'b1;
            end else begin
               state_d = state_q + STW'(1);
            end
         end else begin
            if (state_q == '0) begin
               state_d = MAX_VAL;
               wrap_d  = 1'b1;
            end else begin
               state_d = state_q - STW'(1);
            end
         end
      end
   end

   // State and wrap pulse registers.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wrap_q  <= wrap_d;
      end
   end

   assign state = state_q;
   assign wrap  = wrap_q;

endmodule

// File: rtl/fsm_stepper.sv
// Multi-channel modulo-N_STATES stepper: CH independent channels, a combined
// wrap indication and a sticky error flag for out-of-range loads.
// Build option FSM_STEPPER_EDGE_EN: channels step on rising edges of in.
module fsm_stepper
   import fsm_stepper_pkg::*;
#(
   parameter int  CH       = 4,
   parameter int  N_STATES = 2,
   localparam int STW      = calc_stw(N_STATES)
) (
   input  logic              clk,
   input  logic              areset,
   input  logic [CH-1:0]     en,
   input  logic [CH-1:0]     in,
   input  logic [CH-1:0]     dir,
   input  logic [CH-1:0]     load,
   input  logic [CH*STW-1:0] load_val,
   output logic [CH*STW-1:0] state_out,
   output logic [CH-1:0]     wrap,
   output logic              any_wrap,
   output logic              err
);

   logic [CH-1:0] load_err;
   logic          err_q, err_d;

   for (genvar k = 0; k < CH; k++) begin : g_ch
      fsm_stepper_ch #(
         .N_STATES (N_STATES),
         .STW      (STW)
      ) u_ch (
         .clk      (clk),
         .areset   (areset),
         .en       (en[k]),
         .step_req (in[k]),
         .dir      (dir[k]),
         .load     (load[k]),
         .load_val (load_val[k*STW +: STW]),
         .state    (state_out[k*STW +: STW]),
         .wrap     (wrap[k]),
         .load_err (load_err[k])
      );
   end

   // The error flag latches any channel's bad load and only reset clears it.
   always_comb begin
      err_d = err_q | (|load_err);
   end

   // Sticky error register.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err      = err_q;
   assign any_wrap = |wrap;

endmodule
